// File: rtl/pipeline_hazard_controller_if.sv
// Control bundle between the two-stage pipeline datapath and the hazard controller.
//   master : pipeline side; drives decode/execute status and samples the controls
//   slave  : hazard controller; reads the status and drives PC/pipe-register controls
// Status : op_code_fd, reg_source_1_addr_fd, reg_source_2_addr_fd, alu_source_1_select,
//          alu_source_2_select, reg_dest_addr_em, reg_write_em, mem_read_em,
//          mem_write_em, mem_ready, branch_taken_em, halt_fd
// Control: pc_write_enable, pipe_reg_1_enable, pipe_reg_1_flush, forwarding_enable,
//          halted, mem_error, stall_count
interface pipeline_hazard_controller_if #(
   parameter int unsigned STALL_CNT_W = 8
);
   logic [2:0]             op_code_fd;
   logic [2:0]             reg_source_1_addr_fd;
   logic [1:0]             reg_source_2_addr_fd;
   logic                   alu_source_1_select;
   logic [1:0]             alu_source_2_select;
   logic [2:0]             reg_dest_addr_em;
   logic                   reg_write_em;
   logic                   mem_read_em;
   logic                   mem_write_em;
   logic                   mem_ready;
   logic                   branch_taken_em;
   logic                   halt_fd;
   logic                   pc_write_enable;
   logic                   pipe_reg_1_enable;
   logic                   pipe_reg_1_flush;
   logic                   forwarding_enable;
   logic                   halted;
   logic                   mem_error;
   logic [STALL_CNT_W-1:0] stall_count;

   modport master (
      output op_code_fd, reg_source_1_addr_fd, reg_source_2_addr_fd, alu_source_1_select,
             alu_source_2_select, reg_dest_addr_em, reg_write_em, mem_read_em,
             mem_write_em, mem_ready, branch_taken_em, halt_fd,
      input  pc_write_enable, pipe_reg_1_enable, pipe_reg_1_flush, forwarding_enable,
             halted, mem_error, stall_count
   );

   modport slave (
      input  op_code_fd, reg_source_1_addr_fd, reg_source_2_addr_fd, alu_source_1_select,
             alu_source_2_select, reg_dest_addr_em, reg_write_em, mem_read_em,
             mem_write_em, mem_ready, branch_taken_em, halt_fd,
      output pc_write_enable, pipe_reg_1_enable, pipe_reg_1_flush, forwarding_enable,
             halted, mem_error, stall_count
   );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for the two-stage (fetch/decode -> execute/memory) pipeline.
// Each cycle decides whether the PC and pipe register 1 advance, hold or take a bubble,
// covering load-use hazards, taken branches, variable-latency memory and halt.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; forces a safe bubble while asserted
//   bus   : slave side of pipeline_hazard_controller_if (status in, controls out)
// Outputs are Mealy (state + current inputs); state and counters are registered.
module pipeline_hazard_controller #(
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned MEM_TIMEOUT       = 15,
   parameter int unsigned STALL_CNT_W       = 8
) (
   input logic                         clk,
   input logic                         reset,
   pipeline_hazard_controller_if.slave bus
);

   typedef enum logic [1:0] {StRun, StLoadStall, StMemWait, StHalt} state_e;

   localparam logic [2:0] LoadStallInit = 3'(LOAD_STALL_CYCLES - 1);
   localparam logic [7:0] MemTimeout    = 8'(MEM_TIMEOUT);

   state_e                 state_q, state_d;
   logic [2:0]             stall_left_q, stall_left_d;
   logic [7:0]             wait_cnt_q, wait_cnt_d;
   logic                   mem_error_q, mem_error_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic src1_hit, src2_hit, hazard, mem_busy;
   logic pc_we, pr1_en, pr1_flush, fwd_en, halted;
   logic unused_op_code;

   // Opcode is not needed: the EM-stage flags already classify the instruction.
   assign unused_op_code = ^bus.op_code_fd;

   assign src1_hit = (bus.reg_dest_addr_em == bus.reg_source_1_addr_fd)
                     && !bus.alu_source_1_select;
   // Source 2 reads a register for select 00 (ALU operand) and 01 (store address).
   assign src2_hit = (bus.reg_dest_addr_em == {1'b0, bus.reg_source_2_addr_fd})
                     && !bus.alu_source_2_select[1];
   assign hazard   = bus.mem_read_em && bus.reg_write_em && (bus.reg_dest_addr_em != 3'd0)
                     && (src1_hit || src2_hit);
   assign mem_busy = (bus.mem_read_em || bus.mem_write_em) && !bus.mem_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StRun;
         stall_left_q <= 3'd0;
         wait_cnt_q   <= 8'd0;
         mem_error_q  <= 1'b0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         stall_left_q <= stall_left_d;
         wait_cnt_q   <= wait_cnt_d;
         mem_error_q  <= mem_error_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      stall_left_d = stall_left_q;
      wait_cnt_d   = wait_cnt_q;
      mem_error_d  = mem_error_q;
      unique case (state_q)
         StRun: begin
            if (mem_busy) begin
               wait_cnt_d = 8'd1;
               if (MemTimeout == 8'd1) begin
                  mem_error_d = 1'b1;
                  state_d     = StHalt;
               end else begin
                  state_d = StMemWait;
               end
            end else if (bus.branch_taken_em) begin
               state_d = StRun;
            end else if (hazard) begin
               // The RUN cycle itself is the first bubble.
               if (LOAD_STALL_CYCLES > 1) begin
                  stall_left_d = LoadStallInit;
                  state_d      = StLoadStall;
               end
            end else if (bus.halt_fd) begin
               state_d = StHalt;
            end
         end
         StLoadStall: begin
            stall_left_d = stall_left_q - 3'd1;
            if (stall_left_q <= 3'd1) state_d = StRun;
         end
         StMemWait: begin
            if (bus.mem_ready) begin
               wait_cnt_d = 8'd0;
               state_d    = StRun;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
               if (wait_cnt_d >= MemTimeout) begin
                  mem_error_d = 1'b1;
                  state_d     = StHalt;
               end
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StRun;
      endcase

      stall_cnt_d = stall_cnt_q;
      if (!pc_we && (state_q != StHalt) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_comb begin
      pc_we     = 1'b0;
      pr1_en    = 1'b0;
      pr1_flush = 1'b0;
      fwd_en    = 1'b0;
      halted    = 1'b0;
      if (reset) begin
         pr1_flush = 1'b1;
      end else begin
         unique case (state_q)
            StRun: begin
               fwd_en = 1'b1;
               if (mem_busy) begin
                  pc_we = 1'b0;
               end else if (bus.branch_taken_em) begin
                  pc_we     = 1'b1;
                  pr1_en    = 1'b1;
                  pr1_flush = 1'b1;
               end else if (hazard || bus.halt_fd) begin
                  pr1_en    = 1'b1;
                  pr1_flush = 1'b1;
               end else begin
                  pc_we  = 1'b1;
                  pr1_en = 1'b1;
               end
            end
            StLoadStall: begin
               pr1_en    = 1'b1;
               pr1_flush = 1'b1;
            end
            StMemWait: begin
               // Completion cycle behaves like a clean RUN cycle.
               if (bus.mem_ready) begin
                  pc_we  = 1'b1;
                  pr1_en = 1'b1;
                  fwd_en = 1'b1;
               end
            end
            StHalt: begin
               halted    = 1'b1;
               pr1_flush = 1'b1;
            end
            default: pr1_flush = 1'b1;
         endcase
      end
   end

   assign bus.pc_write_enable   = pc_we;
   assign bus.pipe_reg_1_enable = pr1_en;
   assign bus.pipe_reg_1_flush  = pr1_flush;
   assign bus.forwarding_enable = fwd_en;
   assign bus.halted            = halted;
   assign bus.mem_error         = mem_error_q;
   assign bus.stall_count       = stall_cnt_q;

endmodule
